// File: rtl/button_pkg.sv
// Shared types and default thresholds for the button gesture decoder family.
package button_pkg;

  typedef enum logic [2:0] {
    StIdle          = 3'd0,
    StPressed       = 3'd1,
    StLongHeld      = 3'd2,
    StWaitSecond    = 3'd3,
    StSecondPressed = 3'd4
  } gesture_state_t;

  localparam int unsigned DefTickDiv     = 10000;
  localparam int unsigned DefLongTicks   = 100;
  localparam int unsigned DefDoubleTicks = 30;
  localparam int unsigned DefRepeatTicks = 20;

  // Largest of three thresholds; sizes the shared tick timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider: one-cycle tick every TICK_DIV clk cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the last count of each period, then wrap to zero.
  always_comb begin
    tick_o = (cnt_q == CntMax);
    cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_gesture_decoder.sv
// Turns debounced press/release pulses into short, double, long and repeat gesture pulses.
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DefTickDiv,
  parameter int unsigned LONG_TICKS   = DefLongTicks,
  parameter int unsigned DOUBLE_TICKS = DefDoubleTicks,
  parameter int unsigned REPEAT_TICKS = DefRepeatTicks,
  parameter int unsigned TIMER_WIDTH  = $clog2(max3(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level_i,
  input  logic btn_rise_i,
  input  logic btn_fall_i,
  output logic short_press_o,
  output logic double_press_o,
  output logic long_press_o,
  output logic repeat_press_o,
  output logic busy_o
);

  localparam int unsigned Tw = TIMER_WIDTH;
  // A threshold fires on the tick that lifts the timer from N-1 to N.
  localparam logic [Tw-1:0] LongM1   = Tw'(LONG_TICKS - 1);
  localparam logic [Tw-1:0] DoubleM1 = Tw'(DOUBLE_TICKS - 1);
  localparam logic [Tw-1:0] RepeatM1 = Tw'(REPEAT_TICKS - 1);

  // Level is not needed: the FSM only leaves idle on a rise, so a button held
  // through reset can never produce a gesture.
  logic unused_level;
  assign unused_level = btn_level_i;

  logic tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  gesture_state_t  state_q, state_d;
  logic [Tw-1:0]   timer_q, timer_d, timer_inc;
  logic            short_q, short_d;
  logic            double_q, double_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            busy_q;
  logic            rise_ev, fall_ev;
  logic            long_fire, double_fire, repeat_fire;

  // Edge qualification, saturating timer increment and threshold detection.
  always_comb begin
    // Simultaneous rise and fall cancel each other out.
    rise_ev     = btn_rise_i & ~btn_fall_i;
    fall_ev     = btn_fall_i & ~btn_rise_i;
    timer_inc   = (&timer_q) ? timer_q : timer_q + Tw'(1);
    long_fire   = tick && (timer_q == LongM1);
    double_fire = tick && (timer_q == DoubleM1);
    repeat_fire = tick && (timer_q == RepeatM1);
  end

  // Next-state and pulse decode; edges win over thresholds in the same cycle.
  always_comb begin
    state_d  = state_q;
    timer_d  = tick ? timer_inc : timer_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise_ev) begin
          state_d = StPressed;
          timer_d = '0;
        end
      end
      StPressed: begin
        if (fall_ev) begin
          state_d = StWaitSecond;
          timer_d = '0;
        end else if (long_fire) begin
          state_d = StLongHeld;
          timer_d = '0;
          long_d  = 1'b1;
        end
      end
      StLongHeld: begin
        if (fall_ev) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (repeat_fire) begin
          timer_d  = '0;
          repeat_d = 1'b1;
        end
      end
      StWaitSecond: begin
        if (rise_ev) begin
          state_d = StSecondPressed;
          timer_d = '0;
        end else if (double_fire) begin
          state_d = StIdle;
          timer_d = '0;
          short_d = 1'b1;
        end
      end
      StSecondPressed: begin
        if (fall_ev) begin
          state_d  = StIdle;
          timer_d  = '0;
          double_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and registered outputs; reset aborts any gesture in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign short_press_o  = short_q;
  assign double_press_o = double_q;
  assign long_press_o   = long_q;
  assign repeat_press_o = repeat_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with TICK_DIV=4, LONG=5, DOUBLE=3, REPEAT=2.
module tb_button_gesture_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic btn_rise = 1'b0;
  logic btn_fall = 1'b0;
  logic short_press, double_press, long_press, repeat_press, busy;

  always #5 clk = ~clk;

  button_gesture_decoder #(
    .TICK_DIV    (4),
    .LONG_TICKS  (5),
    .DOUBLE_TICKS(3),
    .REPEAT_TICKS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_level_i   (btn_level),
    .btn_rise_i    (btn_rise),
    .btn_fall_i    (btn_fall),
    .short_press_o (short_press),
    .double_press_o(double_press),
    .long_press_o  (long_press),
    .repeat_press_o(repeat_press),
    .busy_o        (busy)
  );

  // Reference tick phase: counts 0..3 from reset, tick when 3.
  int tb_cnt = 0;
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ev_cyc = 0;
  int n_sh, n_db, n_lg, n_rp, n_busy;
  int c_sh, c_db, c_lg, r1, r2;
  int multi_hot = 0;
  logic sh_busy, sh_prev_busy, prev_busy;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_counts();
    n_sh = 0; n_db = 0; n_lg = 0; n_rp = 0; n_busy = 0;
    c_sh = -1; c_db = -1; c_lg = -1; r1 = -1; r2 = -1;
    sh_busy = 1'bx; sh_prev_busy = 1'bx;
  endtask

  // Advance n cycles, sampling registered outputs 1 time unit after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (short_press) begin
        n_sh++; c_sh = cyc; sh_busy = busy; sh_prev_busy = prev_busy;
      end
      if (double_press) begin n_db++; c_db = cyc; end
      if (long_press) begin n_lg++; c_lg = cyc; end
      if (repeat_press) begin
        if (n_rp == 0) r1 = cyc;
        else if (n_rp == 1) r2 = cyc;
        n_rp++;
      end
      if (busy) n_busy++;
      if ($countones({short_press, double_press, long_press, repeat_press}) > 1) multi_hot++;
      prev_busy = busy;
    end
  endtask

  // One-cycle edge pulse; afterwards we sit in the cycle following the edge.
  task automatic pulse(input logic r, input logic f);
    btn_rise = r;
    btn_fall = f;
    ev_cyc = cyc;
    run(1);
    btn_rise = 1'b0;
    btn_fall = 1'b0;
  endtask

  function automatic int outs();
    return {28'd0, short_press, double_press, long_press, repeat_press};
  endfunction

  initial begin
    int ticks;
    logic found;
    clear_counts();
    prev_busy = 1'b0;

    // Reset state
    run(3);
    check("reset_outs", outs(), 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    check("post_reset_outs", outs(), 0);
    check("tick_phase_start", tb_cnt, 0);
    run(4);
    check("idle_busy", busy, 0);

    // Short press: rise, fall after 2 ticks, then silence
    clear_counts();
    pulse(1'b1, 1'b0);
    check("short_busy_after_rise", busy, 1);
    run(8);
    pulse(1'b0, 1'b1);
    check("short_busy_waiting", busy, 1);
    run(16);
    check("short_count", n_sh, 1);
    check("short_latency_ok", ((c_sh - ev_cyc) >= 10) && ((c_sh - ev_cyc) <= 13), 1);
    check("short_busy_at_pulse", sh_busy, 0);
    check("short_busy_before_pulse", sh_prev_busy, 1);
    check("short_other_pulses", n_db + n_lg + n_rp, 0);

    // Double press
    clear_counts();
    pulse(1'b1, 1'b0);
    run(3);
    pulse(1'b0, 1'b1);
    run(3);
    pulse(1'b1, 1'b0);
    run(3);
    pulse(1'b0, 1'b1);
    check("double_next_cycle", double_press, 1);
    check("double_busy", busy, 0);
    run(20);
    check("double_count", n_db, 1);
    check("double_no_short", n_sh, 0);
    check("double_no_long", n_lg, 0);

    // Long press with repeats, held 10 ticks
    clear_counts();
    btn_level = 1'b1;
    pulse(1'b1, 1'b0);
    run(39);
    check("long_count", n_lg, 1);
    check("long_latency_ok", ((c_lg - ev_cyc) >= 18) && ((c_lg - ev_cyc) <= 21), 1);
    check("repeat_count", n_rp, 2);
    check("repeat1_gap", r1 - c_lg, 8);
    check("repeat2_gap", r2 - r1, 8);
    check("long_busy_held", busy, 1);
    btn_level = 1'b0;
    pulse(1'b0, 1'b1);
    check("long_release_busy", busy, 0);
    run(20);
    check("long_release_no_pulse", n_sh + n_db, 0);
    check("long_total_after", n_lg * 10 + n_rp, 12);

    // Priority race: fall on the tick that would raise the timer to 5
    clear_counts();
    pulse(1'b1, 1'b0);
    ticks = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tb_cnt == 3) ticks++;
      if (ticks == 5) begin
        found = 1'b1;
        break;
      end
      run(1);
    end
    check("race_tick_found", found, 1);
    pulse(1'b0, 1'b1);
    check("race_no_long_now", long_press, 0);
    check("race_busy_waiting", busy, 1);
    run(16);
    check("race_long_count", n_lg, 0);
    check("race_short_count", n_sh, 1);

    // Stray and simultaneous edges
    clear_counts();
    pulse(1'b1, 1'b1);
    check("simul_idle_busy", busy, 0);
    pulse(1'b0, 1'b1);
    check("fall_idle_busy", busy, 0);
    run(20);
    check("stray_idle_pulses", n_sh + n_db + n_lg + n_rp, 0);
    check("stray_idle_busy_cycles", n_busy, 0);
    clear_counts();
    pulse(1'b1, 1'b0);
    run(2);
    pulse(1'b1, 1'b0);
    check("rise_pressed_busy", busy, 1);
    run(2);
    pulse(1'b0, 1'b1);
    run(16);
    check("rise_pressed_short", n_sh, 1);
    check("rise_pressed_no_double", n_db, 0);

    // Reset mid-gesture while held in long-held state
    clear_counts();
    btn_level = 1'b1;
    pulse(1'b1, 1'b0);
    run(27);
    check("rst_mid_long_seen", n_lg, 1);
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    run(1);
    check("rst_mid_outs", outs(), 0);
    check("rst_mid_busy", busy, 0);
    run(1);
    rst = 1'b0;
    check("rst_mid_first_cycle", outs(), 0);
    clear_counts();
    run(60);
    check("rst_held_no_pulse", n_sh + n_db + n_lg + n_rp, 0);
    check("rst_held_busy_cycles", n_busy, 0);
    pulse(1'b1, 1'b0);
    check("rst_new_rise_busy", busy, 1);
    run(2);
    btn_level = 1'b0;
    pulse(1'b0, 1'b1);
    run(16);
    check("rst_new_short", n_sh, 1);

    check("never_multi_hot", multi_hot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
